// File: rtl/scpu_pkg.sv
// Shared scpu definitions: next-PC select encodings, fetch FSM states and
// the default reset PC.
package scpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JAL  = 2'b01,
    PC_JALR = 2'b10,
    PC_RSV  = 2'b11
  } pc_src_e;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_EXEC,
    S_FAULT
  } ifu_state_e;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC adder/mux.
// IFU_MISALIGN_CHECK_EN: when defined, the raw target is passed through and
// fault_o flags target bit 1 set; otherwise the low two bits are cleared.
module ifu_next_pc
  import scpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      pc_src_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic            fault_o,
`endif
  output logic [XLEN-1:0] next_pc_o
);

  logic [XLEN-1:0] raw;

  // Select target; sums wrap modulo 2^XLEN, jalr clears bit 0.
  always_comb begin
    raw = pc_i + XLEN'(4);
    case (pc_src_e'(pc_src_i))
      PC_JAL:  raw = pc_i + imm_i;
      PC_JALR: raw = (rs1_i + imm_i) & ~XLEN'(1);
      default: raw = pc_i + XLEN'(4);
    endcase
  end

`ifdef IFU_MISALIGN_CHECK_EN
  assign fault_o   = raw[1];
  assign next_pc_o = raw;
`else
  assign next_pc_o = raw & ~XLEN'(3);
`endif

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem read per
// instruction, holds the word for decode, then waits for execute to retire
// before stepping the PC.
// IFU_MISALIGN_CHECK_EN: when defined, a next PC with bit 1 set parks the
// FSM in FAULT (exit only by reset) and drives fetch_fault.
module ifu_fetch
  import scpu_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            exec_done,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] npc;
  logic            npc_fault;

  ifu_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc_i      (pc_q),
    .pc_src_i  (pc_src),
    .imm_i     (imm),
    .rs1_i     (rs1_data),
`ifdef IFU_MISALIGN_CHECK_EN
    .fault_o   (npc_fault),
`endif
    .next_pc_o (npc)
  );

`ifndef IFU_MISALIGN_CHECK_EN
  assign npc_fault = 1'b0;
`endif

  // Next-state logic; request valid is registered so it tracks state_d.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_REQ:  if (req_valid_q && imem_req_ready) state_d = S_WAIT;
      S_WAIT: if (imem_rsp_valid) begin
        inst_d    = imem_rsp_data;
        inst_pc_d = pc_q;
        state_d   = S_HOLD;
      end
      S_HOLD: if (inst_ready) state_d = S_EXEC;
      S_EXEC: if (exec_done) begin
        if (npc_fault) begin
          state_d = S_FAULT;
        end else begin
          pc_d    = npc;
          state_d = S_REQ;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_REQ;
    endcase
    req_valid_d = (state_d == S_REQ);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch. The bench plays both the
// instruction memory and decode/execute; expected addresses are hand-computed.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] imm, rs1_data;
  logic        exec_done;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .imm            (imm),
    .rs1_data       (rs1_data),
    .exec_done      (exec_done),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_reqv"},  {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'h8000_0000);
    chk({tag, "_instv"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst"},  inst, 32'd0);
    chk({tag, "_ipc"},   inst_pc, 32'h8000_0000);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  // One full fetch: request (with optional stall), response, decode handshake.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word,
                          input int req_stall, input int inst_stall, input bit stray);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      step();
      n++;
    end
    chk("req_wait", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, addr);
    for (int i = 0; i < req_stall; i++) begin
      step();
      chk("stall_reqv", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_reqv", {31'd0, imem_req_valid}, 32'd0);
    if (stray) begin
      pc_src = 2'b01; imm = 32'h100; exec_done = 1'b1;
      step();
      exec_done = 1'b0;
      chk("stray_reqv", {31'd0, imem_req_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = word;
    step();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'hDEAD_BEEF;
    chk("hold_v",   {31'd0, inst_valid}, 32'd1);
    chk("hold_ins", inst, word);
    chk("hold_pc",  inst_pc, addr);
    for (int i = 0; i < inst_stall; i++) begin
      step();
      chk("istall_v",    {31'd0, inst_valid}, 32'd1);
      chk("istall_ins",  inst, word);
      chk("istall_pc",   inst_pc, addr);
      chk("istall_reqv", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("exec_v",    {31'd0, inst_valid}, 32'd0);
    chk("exec_reqv", {31'd0, imem_req_valid}, 32'd0);
  endtask

  // Retire pulse; a new request must appear in the very next cycle.
  task automatic do_exec(input logic [1:0] src, input logic [31:0] im,
                         input logic [31:0] rs1, input logic [31:0] exp_pc);
    pc_src = src; imm = im; rs1_data = rs1; exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("npc_reqv", {31'd0, imem_req_valid}, 32'd1);
    chk("npc_addr", imem_addr, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0; pc_src = 2'b00; imm = '0; rs1_data = '0; exec_done = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0;
    step(); step();
    chk_reset_state("rst");
    rst_n = 1'b1;
    step();
    chk("rel_reqv", {31'd0, imem_req_valid}, 32'd1);
    chk("rel_addr", imem_addr, 32'h8000_0000);

    do_fetch(32'h8000_0000, 32'h0000_0013, 0, 0, 1'b0);
    do_exec(2'b00, 32'h0, 32'h0, 32'h8000_0004);
    do_fetch(32'h8000_0004, 32'h0040_0093, 5, 3, 1'b0);
    do_exec(2'b01, 32'h0000_000C, 32'h0, 32'h8000_0010);
    do_fetch(32'h8000_0010, 32'hFF1F_F06F, 0, 0, 1'b0);
    do_exec(2'b01, 32'hFFFF_FFF0, 32'h0, 32'h8000_0000);
    do_fetch(32'h8000_0000, 32'h0000_0013, 0, 0, 1'b0);
    do_exec(2'b10, 32'h0000_0004, 32'h8000_0101, 32'h8000_0104);
    do_fetch(32'h8000_0104, 32'h0040_8067, 0, 0, 1'b0);
    do_exec(2'b10, 32'h0000_0004, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 0, 0, 1'b1);
    do_exec(2'b00, 32'h0, 32'h0, 32'h0000_0000);
    do_fetch(32'h0000_0000, 32'h0000_0013, 0, 0, 1'b0);
    do_exec(2'b11, 32'h0000_0040, 32'h0, 32'h0000_0004);
    do_fetch(32'h0000_0004, 32'h0000_0013, 0, 0, 1'b0);

`ifdef IFU_MISALIGN_CHECK_EN
    pc_src = 2'b10; imm = 32'h4; rs1_data = 32'h8000_00FE; exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flt_fault", {31'd0, fetch_fault}, 32'd1);
      chk("flt_reqv",  {31'd0, imem_req_valid}, 32'd0);
      chk("flt_addr",  imem_addr, 32'h0000_0004);
      step();
    end
`else
    do_exec(2'b10, 32'h0000_0004, 32'h8000_00FE, 32'h8000_0100);
    chk("nflt_fault", {31'd0, fetch_fault}, 32'd0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    step();
    imem_rsp_valid = 1'b0;
    chk("mid_hold", {31'd0, inst_valid}, 32'd1);
`endif

    // Reset mid-operation must discard everything.
    rst_n = 1'b0;
    step();
    chk_reset_state("rst2");
    rst_n = 1'b1;
    step();
    chk("rel2_reqv", {31'd0, imem_req_valid}, 32'd1);
    chk("rel2_addr", imem_addr, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
